// File: rtl/pipelined_controller.sv
// Control path of the 5-stage ARM pipeline: Decode, E/M/W control flops
// and the NZCV flags register with Execute-stage condition evaluation.
module pipelined_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemWriteM,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        RegWriteW,
    output logic        MemtoRegE,
    output logic        RegWriteM,
    output logic        PCWrPendingF
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011
    } alu_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_control;
        logic [1:0] flag_write;
        logic       pc_src;
        logic [3:0] cond;
    } id_ex_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pc_src;
    } ex_mem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } mem_wb_t;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       is_dp;
    logic       is_mem;
    logic       is_br;
    logic       unused_rn;

    assign cond      = InstrD[19:16];
    assign op        = InstrD[15:14];
    assign funct     = InstrD[13:8];
    assign cmd       = funct[4:1];
    assign rd        = InstrD[3:0];
    assign unused_rn = ^InstrD[7:4];

    assign is_dp  = (op == 2'b00);
    assign is_mem = (op == 2'b01);
    assign is_br  = (op == 2'b10);

    id_ex_t     dec;
    logic [1:0] reg_src_d;
    logic [1:0] imm_src_d;
    logic       is_cmp;
    logic       is_logic;
    alu_e       alu_d;

    always_comb begin
        alu_d    = ALU_ADD;
        is_cmp   = 1'b0;
        is_logic = 1'b0;
        if (is_dp) begin
            unique case (cmd)
                4'b0100: alu_d = ALU_ADD;
                4'b0010: alu_d = ALU_SUB;
                4'b0000: begin
                    alu_d    = ALU_AND;
                    is_logic = 1'b1;
                end
                4'b1100: begin
                    alu_d    = ALU_ORR;
                    is_logic = 1'b1;
                end
                4'b1010: begin
                    alu_d  = ALU_SUB;
                    is_cmp = 1'b1;
                end
                default: alu_d = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        dec       = '0;
        reg_src_d = 2'b00;
        imm_src_d = 2'b00;
        dec.cond  = cond;
        unique case (1'b1)
            is_dp: begin
                dec.reg_write   = ~is_cmp;
                dec.alu_src     = funct[5];
                dec.alu_control = alu_d;
                // CMP updates flags even without the S bit
                if (funct[0] | is_cmp)
                    dec.flag_write = is_logic ? 2'b10 : 2'b11;
            end
            is_mem: begin
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                imm_src_d       = 2'b01;
                if (funct[0]) begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end else begin
                    dec.mem_write = 1'b1;
                    reg_src_d     = 2'b10;
                end
            end
            is_br: begin
                dec.branch      = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                imm_src_d       = 2'b10;
                reg_src_d       = 2'b01;
            end
            default: dec = '0;
        endcase
        dec.pc_src = (rd == 4'b1111) & dec.reg_write;
    end

    id_ex_t     de;
    ex_mem_t    em;
    mem_wb_t    mw;
    logic [3:0] flags;
    logic       cond_ex;
    logic [1:0] flag_write_e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de <= '0;
        end else if (FlushE) begin
            de <= '0;
        end else begin
            de <= dec;
        end
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        cond_ex = 1'b0;
        unique case (de.cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
        endcase
    end

    assign flag_write_e = de.flag_write & {2{cond_ex}};

    // Flags change at the edge, so cond_ex above sees the pre-update value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_write_e[1])
                flags[3:2] <= ALUFlags[3:2];
            if (flag_write_e[0])
                flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            em <= '0;
        end else begin
            em.reg_write  <= de.reg_write & cond_ex;
            em.mem_write  <= de.mem_write & cond_ex;
            em.mem_to_reg <= de.mem_to_reg;
            em.pc_src     <= de.pc_src & cond_ex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mw <= '0;
        end else begin
            mw.reg_write  <= em.reg_write;
            mw.mem_to_reg <= em.mem_to_reg;
            mw.pc_src     <= em.pc_src;
        end
    end

    assign RegSrcD      = reg_src_d;
    assign ImmSrcD      = imm_src_d;
    assign ALUSrcE      = de.alu_src;
    assign ALUControlE  = de.alu_control;
    assign BranchTakenE = de.branch & cond_ex;
    assign MemtoRegE    = de.mem_to_reg;
    assign MemWriteM    = em.mem_write;
    assign RegWriteM    = em.reg_write;
    assign MemtoRegW    = mw.mem_to_reg;
    assign RegWriteW    = mw.reg_write;
    assign PCSrcW       = mw.pc_src;
    assign PCWrPendingF = dec.pc_src | de.pc_src | em.pc_src;

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Control path for the 5-stage pipelined ARM core.
- Decodes InstrD[31:12] in Decode and carries control bits through its own E/M/W pipeline registers. Drives the datapath's RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegW, PCSrcW and RegWriteW.
- Holds the NZCV flags register, fed by the datapath's ALUFlags, and evaluates ARM condition codes in Execute.
- Sends MemtoRegE, RegWriteM and PCWrPendingF to the hazard unit.

Parameters:
- none (widths fixed by ISA subset)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- InstrD  in  20  Decode instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  datapath ALU flags {N,Z,C,V}, valid in Execute
- FlushE  in  1  synchronous clear of the D->E control register (bubble)
- RegSrcD  out  2  register-address selects for the datapath
- ImmSrcD  out  2  immediate format
- ALUSrcE  out  1  1 = ExtImm to ALU B
- ALUControlE  out  3  ALU operation
- BranchTakenE  out  1  branch resolved taken in Execute
- MemWriteM  out  1  data-memory write enable
- MemtoRegW  out  1  result select: 1 = ReadDataW
- PCSrcW  out  1  non-branch write to R15 in Writeback
- RegWriteW  out  1  register-file write enable
- MemtoRegE  out  1  to hazard unit (load-use detection)
- RegWriteM  out  1  to hazard unit
- PCWrPendingF  out  1  PCSrcD|PCSrcE|PCSrcM, stalls Fetch

Behaviour:
- Decode (combinational on InstrD):
  - Op=00 is data-processing.
    - RegWriteD=1, MemWriteD=0, MemtoRegD=0, BranchD=0.
    - ALUSrcD=Funct[5] (I bit).
    - ImmSrcD=00, RegSrcD=00.
  - Op=01 is memory.
    - L=Funct[0]: LDR has RegWriteD=1, MemtoRegD=1, MemWriteD=0; STR has MemWriteD=1, RegWriteD=0, RegSrcD=10.
    - ALUSrcD=1, ImmSrcD=01, ALUControl=ADD.
    - U bit ignored.
  - Op=10 is branch.
    - BranchD=1, ALUSrcD=1, ImmSrcD=10, RegSrcD=01, ALUControl=ADD, no writes.
  - Op=11 decodes to all zeros (NOP).
- ALUControlD for DP, from cmd=Funct[4:1]:
  - 0100 ADD -> 000; 0010 SUB -> 001; 0000 AND -> 010; 1100 ORR -> 011.
  - 1010 CMP -> 001 with RegWriteD forced 0.
  - Any other cmd -> 000.
- FlagWriteD[1:0] (DP only, when S=Funct[0]=1):
  - bit1 enables the {N,Z} update; bit0 enables the {C,V} update.
  - Logic ops (AND/ORR) set bit1 only; ADD/SUB/CMP set both bits.
  - CMP always sets both bits.
- PCSrcD = (Rd==4'b1111) & RegWriteD.
- D->E register: captures RegWrite, MemWrite, MemtoReg, Branch, ALUSrc, ALUControl, FlagWrite, PCSrc and Cond.
  - FlushE=1 loads all zeros.
- Execute:
  - CondExE is the standard ARM condition evaluation of CondE against the stored Flags (EQ..LE, 1110 AL=1); 1111 gives 0.
  - Every side-effect bit is gated by CondExE before the M register (RegWrite, MemWrite, PCSrc, FlagWrite).
  - BranchTakenE = BranchE & CondExE.
- Flags register:
  - [3:2] loads ALUFlags[3:2] on a clock edge when FlagWriteE[1]&CondExE.
  - [1:0] loads ALUFlags[1:0] when FlagWriteE[0]&CondExE.
  - CondExE uses the pre-update value (an instruction never sees its own flags).
- E->M and M->W registers are plain flops with no stall or flush.
- Latency: a Decode instruction's RegWrite, MemtoReg and PCSrc reach the W outputs exactly 3 cycles later. MemWriteM appears 2 cycles later.
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM. The D and E terms are ungated by CondEx; the M term is gated.
- Reset (asynchronous, active-low):
  - reset=0 immediately forces every pipeline register and Flags to 0.
  - All E/M/W outputs therefore read 0.
  - Asserting reset mid-operation discards all in-flight control.
  - The first instruction after reset release sees Flags=0000.
- Simultaneous events:
  - FlushE with a flag-setting instruction in Execute: Flags update still occurs, since the flush acts on the incoming D->E data only.

Test Plan:
- Flags and conditional skip:
  - Stimulus: ADDS with ALUFlags=0100, then ADDEQ, then ADDNE; R0 writes in all three.
  - Required: Flags=0100 after the ADDS edge; ADDEQ gives RegWriteW=1 three cycles later; ADDNE gives RegWriteW=0.
- Branch:
  - Stimulus: B (cond AL) in Decode.
  - Required: BranchTakenE=1 the next cycle, ALUSrcE=1, ALUControlE=000; RegWriteW stays 0.
- Load:
  - Stimulus: LDR R1.
  - Required: MemtoRegE=1 at +1, RegWriteM=1 at +2, MemtoRegW=1 and RegWriteW=1 at +3; MemWriteM=0.
- Flush bubble:
  - Stimulus: STR in Decode with FlushE=1.
  - Required: MemWriteM=0 two cycles later, and every E output is 0 the next cycle.
- PC write:
  - Stimulus: MOV-class ADD with Rd=1111.
  - Required: PCWrPendingF=1 for 3 consecutive cycles; PCSrcW=1 on the 3rd cycle after Decode.
- Reset mid-operation:
  - Stimulus: reset driven 0 asynchronously between clock edges while LDR is in M.
  - Required: RegWriteM, MemtoRegW and Flags go to 0 before the next clock edge.
